// File: rtl/btn_event_ctrl.sv
// btn_event_ctrl: per-channel sync + tick-based debounce, PRESS/LONG/RELEASE event
// generation and round-robin arbitration onto one valid/ready event port.
`default_nettype none

module btn_event_ctrl #(
  parameter int N_BTN        = 4,
  parameter int TICK_CYCLES  = 100000,
  parameter int STABLE_TICKS = 10,
  parameter int LONG_TICKS   = 1000
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic [N_BTN-1:0]         bouncey_in,
  output logic [N_BTN-1:0]         clean_out,
  output logic                     event_valid_out,
  input  logic                     event_ready_in,
  output logic [$clog2(N_BTN)-1:0] event_ch_out,
  output logic [1:0]               event_type_out,
  output logic [N_BTN-1:0]         overflow_out
);

  localparam int CW = $clog2(N_BTN);
  localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int SW = $clog2(STABLE_TICKS + 1);
  localparam int HW = $clog2(LONG_TICKS + 1);

  localparam logic [PW-1:0] TICK_LAST   = PW'(TICK_CYCLES - 1);
  localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_TICKS - 1);
  localparam logic [HW-1:0] LONG_LAST   = HW'(LONG_TICKS - 1);
  localparam logic [HW-1:0] LONG_MAX    = HW'(LONG_TICKS);
  localparam logic [CW-1:0] CH_LAST     = CW'(N_BTN - 1);

  localparam logic [1:0] TYPE_PRESS   = 2'b01;
  localparam logic [1:0] TYPE_RELEASE = 2'b10;
  localparam logic [1:0] TYPE_LONG    = 2'b11;

  logic [N_BTN-1:0] sync_meta, sync_lvl;
  logic [PW-1:0]    presc;
  logic             tick;
  logic [SW-1:0]    stable_cnt [N_BTN];
  logic [HW-1:0]    hold_cnt   [N_BTN];

  logic [N_BTN-1:0] toggle, press_ev, long_ev, rel_ev;
  logic [N_BTN-1:0] press_pend, long_pend, rel_pend, any_pend;
  logic [N_BTN-1:0] press_clr, long_clr, rel_clr;

  logic [CW-1:0]    rr_ptr, sel_ch, idx;
  logic [1:0]       sel_type;
  logic             found, load;

  assign tick     = (presc == TICK_LAST);
  assign press_ev = toggle & ~clean_out;
  assign rel_ev   = toggle & clean_out;
  assign any_pend = press_pend | long_pend | rel_pend;
  assign load     = !event_valid_out || event_ready_in;

  always_comb begin
    toggle  = '0;
    long_ev = '0;
    for (int i = 0; i < N_BTN; i++) begin
      toggle[i]  = tick && (sync_lvl[i] != clean_out[i]) && (stable_cnt[i] == STABLE_LAST);
      // LONG fires only on a tick that is not also a clean edge
      long_ev[i] = tick && clean_out[i] && hold_cnt[i] == LONG_LAST &&
                   ((sync_lvl[i] == clean_out[i]) || (stable_cnt[i] != STABLE_LAST));
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      sync_meta <= '0;
      sync_lvl  <= '0;
      presc     <= '0;
      clean_out <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        stable_cnt[i] <= '0;
        hold_cnt[i]   <= '0;
      end
    end else begin
      sync_meta <= bouncey_in;
      sync_lvl  <= sync_meta;
      presc     <= tick ? '0 : presc + PW'(1);
      for (int i = 0; i < N_BTN; i++) begin
        if (tick) begin
          if (sync_lvl[i] == clean_out[i]) begin
            stable_cnt[i] <= '0;
          end else if (toggle[i]) begin
            clean_out[i]  <= ~clean_out[i];
            stable_cnt[i] <= '0;
          end else begin
            stable_cnt[i] <= stable_cnt[i] + SW'(1);
          end
        end
        if (toggle[i]) begin
          hold_cnt[i] <= '0;
        end else if (tick && clean_out[i] && hold_cnt[i] != LONG_MAX) begin
          hold_cnt[i] <= hold_cnt[i] + HW'(1);
        end
      end
    end
  end

  // Round-robin scan from rr_ptr; PRESS > LONG > RELEASE within a channel
  always_comb begin
    found     = 1'b0;
    sel_ch    = '0;
    idx       = '0;
    sel_type  = TYPE_RELEASE;
    press_clr = '0;
    long_clr  = '0;
    rel_clr   = '0;
    for (int k = 0; k < N_BTN; k++) begin
      idx = CW'((int'(rr_ptr) + k) % N_BTN);
      if (!found && any_pend[idx]) begin
        found  = 1'b1;
        sel_ch = idx;
      end
    end
    if (press_pend[sel_ch]) begin
      sel_type = TYPE_PRESS;
    end else if (long_pend[sel_ch]) begin
      sel_type = TYPE_LONG;
    end
    if (load && found) begin
      if (press_pend[sel_ch]) begin
        press_clr[sel_ch] = 1'b1;
      end else if (long_pend[sel_ch]) begin
        long_clr[sel_ch] = 1'b1;
      end else begin
        rel_clr[sel_ch] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      press_pend   <= '0;
      long_pend    <= '0;
      rel_pend     <= '0;
      overflow_out <= '0;
    end else begin
      press_pend   <= press_ev | (press_pend & ~press_clr);
      long_pend    <= long_ev  | (long_pend  & ~long_clr);
      rel_pend     <= rel_ev   | (rel_pend   & ~rel_clr);
      overflow_out <= overflow_out
                    | (press_ev & press_pend & ~press_clr)
                    | (long_ev  & long_pend  & ~long_clr)
                    | (rel_ev   & rel_pend   & ~rel_clr);
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      event_valid_out <= 1'b0;
      event_ch_out    <= '0;
      event_type_out  <= 2'b00;
      rr_ptr          <= '0;
    end else if (load) begin
      event_valid_out <= found;
      if (found) begin
        event_ch_out   <= sel_ch;
        event_type_out <= sel_type;
        rr_ptr         <= (sel_ch == CH_LAST) ? '0 : sel_ch + CW'(1);
      end
    end
  end

endmodule

`default_nettype wire
